// File: rtl/imem_loader.sv
// Byte-wide instruction memory: stream loader writing big-endian bytes plus a registered fetch port.
// Optional running word checksum output is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_BYTES = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t      state;
  logic [31:0] ptr;
  logic [31:0] shift;
  logic        last;
  logic [1:0]  cnt;
  logic [7:0]  mem [MEM_BYTES];
  logic        fits;
  logic [31:0] fetch_next;

  // 33-bit compare so a base address near 2^32 cannot wrap into range.
  assign fits = ({1'b0, ptr} + 33'd4) <= 33'(MEM_BYTES);

  assign wr_ready = (state == ACCEPT);
  assign busy     = (state == ACCEPT) || (state == WRITE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      shift <= '0;
      last  <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= start_addr;
            err   <= 1'b0;
            state <= ACCEPT;
`ifdef LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        ACCEPT: begin
          if (wr_valid) begin
            if (fits) begin
              shift <= wr_data;
              last  <= wr_last;
              cnt   <= '0;
              state <= WRITE;
`ifdef LOADER_CHECKSUM_EN
              checksum <= checksum + wr_data;
`endif
            end else begin
              // Word is consumed and dropped; nothing of it reaches memory.
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        WRITE: begin
          shift <= {shift[23:0], 8'h00};
          ptr   <= ptr + 32'd1;
          cnt   <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= last ? DONE : ACCEPT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      mem[ptr[AW-1:0]] <= shift[31:24];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    logic [32:0] byte_addr;
    assign byte_addr = {1'b0, fetch_addr} + 33'(gi);
    assign fetch_next[31-8*gi -: 8] =
      (byte_addr < 33'(MEM_BYTES)) ? mem[byte_addr[AW-1:0]] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_instr <= '0;
    end else begin
      fetch_instr <= fetch_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven sessions, hand-written corner sequences and
// randomized sessions checked against a byte-array reference model.
module tb_imem_loader;
  localparam int MEM = 28;

  logic        clk = 1'b0;
  logic        rst, start, wr_valid, wr_last;
  logic        wr_ready, busy, done, err;
  logic [31:0] start_addr, wr_data, fetch_addr, fetch_instr;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  mm [MEM];
  longint      mptr;
  logic        merr;
  logic [31:0] msum;

  typedef struct {
    logic [31:0] addr;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting (got none, expected event)", name);
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      x = 64'(a) + 64'(k);
      r[31-8*k -: 8] = (x < MEM) ? mm[int'(x)] : 8'h00;
    end
    return r;
  endfunction

  // Returns 1 if the word fits and is written into the model.
  function automatic bit model_word(input logic [31:0] d);
    if (mptr + 4 <= MEM) begin
      for (int k = 0; k < 4; k++) mm[int'(mptr) + k] = d[31-8*k -: 8];
      msum = msum + d;
      mptr = mptr + 4;
      return 1'b1;
    end
    merr = 1'b1;
    return 1'b0;
  endfunction

  task automatic start_session(input logic [31:0] a);
    start = 1'b1; start_addr = a;
    mptr = longint'(64'(a)); merr = 1'b0; msum = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = l;
    while (!wr_ready && t < 20) begin @(negedge clk); t++; end
    if (!wr_ready) fail_timeout("wr_ready");
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int lat);
    int t;
    t = 0;
    while (!done && t < 20) begin @(negedge clk); t++; end
    if (!done) fail_timeout("done");
    else begin
      check("done_latency", t, lat);
      check("busy_at_done", busy, 1'b0);
    end
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic verify_mem();
    for (int a = 0; a <= MEM; a++) begin
      fetch_addr = (a == MEM) ? 32'hFFFF_FFFF : a;
      @(negedge clk);
      check($sformatf("fetch@%08h", fetch_addr), fetch_instr, mread(fetch_addr));
    end
  endtask

  task automatic run_session(input logic [31:0] a, input int n, input logic [31:0] w0,
                             input logic [31:0] w1, input bit use_tbl, input logic exp_err);
    logic [31:0] w;
    logic        l;
    bit          ok;
    start_session(a);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : $urandom;
      l = (k == n - 1);
      ok = model_word(w);
      send_word(w, l);
      if (!ok) begin wait_done(0); break; end
      if (l) wait_done(4);
    end
    check("err", err, use_tbl ? exp_err : merr);
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum, msum);
`endif
    $display("session addr=%08h words=%0d err=%0b", a, n, err);
    verify_mem();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got hang, expected finish)");
    $fatal(1);
  end

  initial begin
    int          acc_cyc [3];
    int          nacc, i;
    logic [31:0] tw [3];
    logic [31:0] w;
    bit          ok;

    tbl[0] = '{32'd0,          7, 32'h1111_2222, 32'h3333_4444, 1'b0}; // fill whole memory
    tbl[1] = '{32'd0,          2, 32'h2008_0005, 32'h2009_000A, 1'b0}; // basic load
    tbl[2] = '{32'd24,         2, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1}; // overflow on 2nd word
    tbl[3] = '{32'd5,          3, 32'h0102_0304, 32'h0506_0708, 1'b0}; // misaligned base
    tbl[4] = '{32'd26,         1, 32'h9999_9999, 32'h0,         1'b1}; // overflow on 1st word
    tbl[5] = '{32'd0,          2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0}; // checksum wrap
    tbl[6] = '{32'hFFFF_FFFE,  1, 32'h7777_7777, 32'h0,         1'b1}; // no pointer wrap

    rst = 1'b1; start = 1'b0; start_addr = '0; wr_valid = 1'b0; wr_data = '0;
    wr_last = 1'b0; fetch_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_fetch_instr", fetch_instr, 32'h0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_checksum", checksum, 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_session(tbl[v].addr, tbl[v].n, tbl[v].w0, tbl[v].w1, 1'b1, tbl[v].exp_err);
      if (v == 1) begin
        fetch_addr = 32'd4;
        @(negedge clk);
        check("basic_fetch4", fetch_instr, 32'h2009_000A);
      end
`ifdef LOADER_CHECKSUM_EN
      if (v == 5) check("checksum_wrap", checksum, 32'h0000_0001);
`endif
    end

    // Throughput: valid held high, start held high to prove it is ignored while busy.
    for (int k = 0; k < 3; k++) tw[k] = $urandom;
    start = 1'b1; start_addr = '0;
    mptr = 0; merr = 1'b0; msum = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) ok = model_word(tw[k]);
    nacc = 0; i = 0;
    wr_valid = 1'b1; wr_data = tw[0]; wr_last = 1'b0;
    while (nacc < 3 && i < 40) begin
      if (wr_ready) begin acc_cyc[nacc] = i; nacc++; end
      @(negedge clk); i++;
      if (nacc < 3) begin wr_data = tw[nacc]; wr_last = (nacc == 2); end
    end
    wr_valid = 1'b0; start = 1'b0;
    if (nacc < 3) fail_timeout("throughput_accepts");
    else begin
      check("throughput_gap1", acc_cyc[1] - acc_cyc[0], 5);
      check("throughput_gap2", acc_cyc[2] - acc_cyc[1], 5);
      wait_done(4);
    end
    $display("session throughput words=3 accepts=%0d", nacc);
    verify_mem();

    // Reset after the second byte of a word.
    start_session(32'd8);
    send_word(32'hAABB_CCDD, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_wr_ready", wr_ready, 1'b0);
    check("rst_mid_done", done, 1'b0);
    mm[8] = 8'hAA; mm[9] = 8'hBB;
    @(negedge clk);
    check("rst_mid_busy_hold", busy, 1'b0);
    rst = 1'b0;
    $display("session reset_mid addr=00000008");
    verify_mem();

    // Same-edge read of a byte being written returns its previous value.
    start_session(32'd12);
    w = $urandom;
    send_word(w, 1'b1);
    fetch_addr = 32'd12;
    @(negedge clk);
    check("collision_old", fetch_instr, mread(32'd12));
    ok = model_word(w);
    wait_done(3);
    check("collision_err", err, 1'b0);
    $display("session collision addr=0000000c word=%08h", w);
    verify_mem();

    for (int r = 0; r < 8; r++) begin
      run_session($urandom_range(0, 30), $urandom_range(1, 4), $urandom, $urandom, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
